// File: rtl/useq_io.sv
// useq_io: I/O shell for a micro-sequencer: stretched reset, input synchronisers,
// a ticker, and host<->FIFO byte bridges in both directions.
// Ports: clk, rst_n (async, active low); ext_in/div_val feed i_port; useq_rst_n
// drives the sequencer reset; write_fifo/fifo_in/fifo_full face the RX FIFO;
// read_fifo/fifo_out/fifo_empty face the TX FIFO; host_tx_* and host_rx_* are
// valid/ready byte streams.
// Build option: USEQ_IO_EDGE_IRQ_EN adds a sticky ext_in[0] rising-edge flag on
// i_port[7], cleared by o_port[7].
module useq_io #(
  parameter int N_IN        = 2,
  parameter int DIV_W       = 16,
  parameter int RST_STRETCH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  ext_in,
  input  logic [DIV_W-1:0] div_val,
  output logic             useq_rst_n,
  output logic [7:0]       i_port,
  input  logic [7:0]       o_port,
  output logic             write_fifo,
  output logic [7:0]       fifo_in,
  input  logic             fifo_full,
  output logic             read_fifo,
  input  logic [7:0]       fifo_out,
  input  logic             fifo_empty,
  input  logic [7:0]       host_tx_data,
  input  logic             host_tx_valid,
  output logic             host_tx_ready,
  output logic [7:0]       host_rx_data,
  output logic             host_rx_valid,
  input  logic             host_rx_ready
);
  typedef enum logic [1:0] {TIDLE, TWRITE, TSETTLE} tx_t;
  typedef enum logic [1:0] {RIDLE, RREAD, RCAPT} rx_t;
  logic [3:0] str_q;
  logic urst_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic tick_q;
  logic term;
  logic [N_IN-1:0] s1_q, s2_q;
  logic irq;
  logic [7:0] hold_q;
  logic hold_v_q;
  tx_t tx_q;
  rx_t rx_q;
  assign useq_rst_n = urst_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      str_q  <= '0;
      urst_q <= 1'b0;
    end else if (!urst_q) begin
      if (str_q == 4'(RST_STRETCH - 1)) urst_q <= 1'b1;
      else str_q <= str_q + 4'd1;
    end
  // >= rather than == so a lowered div_val wraps at once instead of running to 2^DIV_W
  assign term = div_cnt_q >= div_val;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
    end else begin
      div_cnt_q <= term ? '0 : div_cnt_q + DIV_W'(1);
      tick_q    <= tick_q ^ term;
      s1_q      <= ext_in;
      s2_q      <= s1_q;
    end
`ifdef USEQ_IO_EDGE_IRQ_EN
  logic prev_q, irq_q;
  logic unused_o;
  assign unused_o = ^o_port[6:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      prev_q <= s2_q[0];
      irq_q  <= (s2_q[0] & ~prev_q) | (irq_q & ~o_port[7]);
    end
  assign irq = irq_q;
`else
  logic unused_o;
  assign unused_o = ^o_port;
  assign irq = 1'b0;
`endif
  always_comb begin
    i_port         = '0;
    i_port[0]      = tick_q;
    i_port[N_IN:1] = s2_q;
    i_port[7]      = irq;
  end
  assign host_tx_ready = ~hold_v_q & urst_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      tx_q       <= TIDLE;
      write_fifo <= 1'b0;
      fifo_in    <= '0;
    end else begin
      if (host_tx_valid && host_tx_ready) begin
        hold_q   <= host_tx_data;
        hold_v_q <= 1'b1;
      end
      case (tx_q)
        TIDLE: if (hold_v_q && !fifo_full && urst_q) begin
          tx_q       <= TWRITE;
          write_fifo <= 1'b1;
          fifo_in    <= hold_q;
          hold_v_q   <= 1'b0;
        end
        TWRITE: begin
          tx_q       <= TSETTLE;
          write_fifo <= 1'b0;
        end
        default: tx_q <= TIDLE;
      endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_q          <= RIDLE;
      read_fifo     <= 1'b0;
      host_rx_data  <= '0;
      host_rx_valid <= 1'b0;
    end else begin
      if (host_rx_valid && host_rx_ready) host_rx_valid <= 1'b0;
      case (rx_q)
        RIDLE: if (!fifo_empty && !host_rx_valid && urst_q) begin
          rx_q      <= RREAD;
          read_fifo <= 1'b1;
        end
        RREAD: begin
          rx_q      <= RCAPT;
          read_fifo <= 1'b0;
        end
        default: begin
          rx_q          <= RIDLE;
          host_rx_data  <= fifo_out;
          host_rx_valid <= 1'b1;
        end
      endcase
    end
endmodule
